// File: rtl/m_ucode_loader.sv
`default_nettype none
// ============================================================================
// Module : m_ucode_loader
// Boot-time byte-stream loader for the 48-bit microcode store. It holds the
// CPU off until the image is written and, optionally, checksum-verified.
// Rev    : 1.0
// ============================================================================
module m_ucode_loader #(
    parameter int NWORDS = 256,
    parameter int CHECK  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_dat,
    input  logic        in_stb,
    output logic        in_ack,
    output logic        we,
    output logic [7:0]  wadr,
    output logic [47:0] wdat,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [7:0] c_LAST_ADR  = 8'(NWORDS - 1);
    localparam logic [2:0] c_LAST_BYTE = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [2:0]  r_cnt;
    logic [7:0]  r_acc;
    logic [7:0]  r_wadr;
    logic [47:0] r_wdat;

    logic        w_xfer;
    logic        w_start_ok;
    logic        w_last_word;
    logic [7:0]  w_acc_sum;

    assign w_xfer      = in_stb & in_ack;
    assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_DONE) |
                                  (r_state == S_ERR));
    assign w_last_word = (r_wadr == c_LAST_ADR);
    assign w_acc_sum   = r_acc + in_dat;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_xfer && (r_cnt == c_LAST_BYTE)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_last_word) begin
                    w_state_nxt = (CHECK != 0) ? S_CHECK : S_DONE;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_CHECK: begin
                // Image bytes plus checksum byte must sum to zero modulo 256.
                if (w_xfer) begin
                    w_state_nxt = (w_acc_sum == 8'h00) ? S_DONE : S_ERR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs decoded from the state register; the write strobe therefore
    // drops with the asynchronous reset, so a partial word is never written.
    // ------------------------------------------------------------------------
    always_comb begin
        in_ack   = 1'b0;
        we       = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b1;
        case (r_state)
            S_LOAD: begin
                in_ack = in_stb;
                busy   = 1'b1;
            end
            S_WRITE: begin
                we   = 1'b1;
                busy = 1'b1;
            end
            S_CHECK: begin
                in_ack = in_stb;
                busy   = 1'b1;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                cpu_hold = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: byte counter, checksum accumulator, write address and word
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 3'd0;
            r_acc  <= 8'h00;
            r_wadr <= 8'h00;
            r_wdat <= 48'h0;
        end else if (w_start_ok) begin
            r_cnt  <= 3'd0;
            r_acc  <= 8'h00;
            r_wadr <= 8'h00;
        end else begin
            if (w_xfer) begin
                r_acc <= w_acc_sum;
            end
            if ((r_state == S_LOAD) && w_xfer) begin
                for (int i = 0; i < 6; i++) begin
                    if (r_cnt == 3'(i)) begin
                        r_wdat[8*i +: 8] <= in_dat;
                    end
                end
                r_cnt <= (r_cnt == c_LAST_BYTE) ? 3'd0 : r_cnt + 3'd1;
            end
            if ((r_state == S_WRITE) && !w_last_word) begin
                r_wadr <= r_wadr + 8'd1;
            end
        end
    end

    assign wadr = r_wadr;
    assign wdat = r_wdat;

endmodule
`default_nettype wire

// File: tb/tb_m_ucode_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_m_ucode_loader
// Scoreboard bench for m_ucode_loader: a 256-word/checksum instance and a
// 4-word/no-checksum instance driven with directed byte streams.
// Rev    : 1.0
// ============================================================================
module tb_m_ucode_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_b = 1'b0, stb_b = 1'b0;
    logic [7:0]  dat_b = 8'h00;
    logic        ack_b, we_b, busy_b, done_b, err_b, hold_b;
    logic [7:0]  wadr_b;
    logic [47:0] wdat_b;

    logic        start_s = 1'b0, stb_s = 1'b0;
    logic [7:0]  dat_s = 8'h00;
    logic        ack_s, we_s, busy_s, done_s, err_s, hold_s;
    logic [7:0]  wadr_s;
    logic [47:0] wdat_s;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int we_cnt_b = 0, we_cnt_s = 0;
    int ack_viol = 0;
    logic [47:0] cap0, cap255, cap3s;
    logic [55:0] q_b[$];
    logic [55:0] q_s[$];

    m_ucode_loader #(.NWORDS(256), .CHECK(1)) u_big (
        .clk(clk), .rst(rst), .start(start_b), .in_dat(dat_b), .in_stb(stb_b),
        .in_ack(ack_b), .we(we_b), .wadr(wadr_b), .wdat(wdat_b), .busy(busy_b),
        .done(done_b), .err(err_b), .cpu_hold(hold_b)
    );

    m_ucode_loader #(.NWORDS(4), .CHECK(0)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .in_dat(dat_s), .in_stb(stb_s),
        .in_ack(ack_s), .we(we_s), .wadr(wadr_s), .wdat(wdat_s), .busy(busy_s),
        .done(done_s), .err(err_s), .cpu_hold(hold_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected write whenever a write strobe is seen.
    always @(negedge clk) begin
        logic [55:0] e;
        if (we_b) begin
            we_cnt_b++;
            if (wadr_b == 8'd0)   cap0   = wdat_b;
            if (wadr_b == 8'd255) cap255 = wdat_b;
            if (q_b.size() == 0) begin
                check("unexpected_we_big", 64'(wadr_b), 64'hFFFF);
            end else begin
                e = q_b.pop_front();
                check("wadr_big", 64'(wadr_b), 64'(e[55:48]));
                check("wdat_big", 64'(wdat_b), 64'(e[47:0]));
            end
        end
        if (we_s) begin
            we_cnt_s++;
            if (wadr_s == 8'd3) cap3s = wdat_s;
            if (q_s.size() == 0) begin
                check("unexpected_we_small", 64'(wadr_s), 64'hFFFF);
            end else begin
                e = q_s.pop_front();
                check("wadr_small", 64'(wadr_s), 64'(e[55:48]));
                check("wdat_small", 64'(wdat_s), 64'(e[47:0]));
            end
        end
        if ((ack_b && (!stb_b || we_b)) || (ack_s && (!stb_s || we_s))) ack_viol++;
    end

    // Offers one byte and returns at posedge+1 after the edge that took it.
    task automatic send(input bit sel, input logic [7:0] b, input bit gapped);
        int  n;
        bit  got;
        if (gapped) begin
            while ($urandom_range(0, 9) >= 3) begin
                if (sel) stb_s = 1'b0; else stb_b = 1'b0;
                @(posedge clk); #1;
            end
        end
        if (sel) begin dat_s = b; stb_s = 1'b1; end
        else     begin dat_b = b; stb_b = 1'b1; end
        n = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = sel ? ack_s : ack_b;
            @(posedge clk); #1;
            n++;
        end
        if (!got) check("ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_start(input bit sel, output int t0);
        if (sel) start_s = 1'b1; else start_b = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start_s = 1'b0;
        start_b = 1'b0;
    endtask

    // Byte i of the image is i mod 256; word w is bytes 6w..6w+5, little-endian.
    task automatic load_big(input bit gapped, input logic [7:0] ck, input int start_w,
                            input int stop_w, output int t0);
        logic [47:0] m;
        m = '0;
        pulse_start(1'b0, t0);
        for (int w = 0; w < 256; w++) begin
            for (int j = 0; j < 6; j++) begin
                if (w == stop_w && j == 5) return;
                if (w == start_w && j == 3) begin
                    stb_b = 1'b0;
                    start_b = 1'b1;
                    @(posedge clk); #1;
                    start_b = 1'b0;
                end
                m[8*j +: 8] = 8'(6 * w + j);
                if (j == 5) q_b.push_back({8'(w), m});
                send(1'b0, 8'(6 * w + j), gapped);
            end
        end
        send(1'b0, ck, gapped);
        stb_b = 1'b0;
    endtask

    initial begin
        int t0;
        logic [47:0] m;

        // Reset state, with a byte presented to show it is not acknowledged.
        stb_b = 1'b1;
        #2;
        check("rst_we", 64'(we_b), 64'd0);
        check("rst_busy", 64'(busy_b), 64'd0);
        check("rst_done", 64'(done_b), 64'd0);
        check("rst_err", 64'(err_b), 64'd0);
        check("rst_ack", 64'(ack_b), 64'd0);
        check("rst_wadr", 64'(wadr_b), 64'd0);
        check("rst_wdat", 64'(wdat_b), 64'd0);
        check("rst_hold", 64'(hold_b), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_ack", 64'(ack_b), 64'd0);
        @(posedge clk); #1;
        stb_b = 1'b0;

        // Full image at maximum rate.
        we_cnt_b = 0;
        load_big(1'b0, 8'h00, -1, -1, t0);
        check("full_done_cycle", 64'(cyc - t0), 64'd1794);
        @(negedge clk);
        check("full_done", 64'(done_b), 64'd1);
        check("full_hold", 64'(hold_b), 64'd0);
        check("full_busy", 64'(busy_b), 64'd0);
        check("full_we_count", 64'(we_cnt_b), 64'd256);
        check("full_word0", 64'(cap0), 64'h050403020100);
        check("full_word255", 64'(cap255), 64'hFFFEFDFCFBFA);
        check("full_sb_empty", 64'(q_b.size()), 64'd0);
        @(posedge clk); #1;

        // Bad checksum.
        we_cnt_b = 0;
        load_big(1'b0, 8'h01, -1, -1, t0);
        @(negedge clk);
        check("bad_err", 64'(err_b), 64'd1);
        check("bad_hold", 64'(hold_b), 64'd1);
        check("bad_done", 64'(done_b), 64'd0);
        check("bad_busy", 64'(busy_b), 64'd0);
        check("bad_we_count", 64'(we_cnt_b), 64'd256);
        @(posedge clk); #1;
        @(negedge clk);
        check("bad_err_sticky", 64'(err_b), 64'd1);
        @(posedge clk); #1;
        pulse_start(1'b0, t0);
        @(negedge clk);
        check("restart_err_clr", 64'(err_b), 64'd0);
        check("restart_busy", 64'(busy_b), 64'd1);
        @(posedge clk); #1;

        // Gapped stream; the block is already in LOAD, so the start is ignored.
        we_cnt_b = 0;
        ack_viol = 0;
        load_big(1'b1, 8'h00, -1, -1, t0);
        @(negedge clk);
        check("gap_done", 64'(done_b), 64'd1);
        check("gap_we_count", 64'(we_cnt_b), 64'd256);
        check("gap_word255", 64'(cap255), 64'hFFFEFDFCFBFA);
        check("gap_ack_protocol", 64'(ack_viol), 64'd0);
        @(posedge clk); #1;

        // Start pulse in the middle of word 10.
        we_cnt_b = 0;
        load_big(1'b0, 8'h00, 10, -1, t0);
        @(negedge clk);
        check("midstart_done", 64'(done_b), 64'd1);
        check("midstart_we_count", 64'(we_cnt_b), 64'd256);
        check("midstart_sb_empty", 64'(q_b.size()), 64'd0);
        @(posedge clk); #1;

        // Reset after byte 4 of word 20, then a full clean load.
        we_cnt_b = 0;
        load_big(1'b0, 8'h00, -1, 20, t0);
        stb_b = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_we", 64'(we_b), 64'd0);
        check("rst_mid_busy", 64'(busy_b), 64'd0);
        check("rst_mid_hold", 64'(hold_b), 64'd1);
        check("rst_mid_wadr", 64'(wadr_b), 64'd0);
        check("rst_mid_we_count", 64'(we_cnt_b), 64'd20);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        we_cnt_b = 0;
        load_big(1'b0, 8'h00, -1, -1, t0);
        check("reload_done_cycle", 64'(cyc - t0), 64'd1794);
        @(negedge clk);
        check("reload_done", 64'(done_b), 64'd1);
        check("reload_we_count", 64'(we_cnt_b), 64'd256);
        check("reload_word0", 64'(cap0), 64'h050403020100);
        @(posedge clk); #1;

        // Small image without checksum: bytes 0x11..0x28.
        we_cnt_s = 0;
        ack_viol = 0;
        pulse_start(1'b1, t0);
        m = '0;
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < 6; j++) begin
                m[8*j +: 8] = 8'(8'h11 + 6 * w + j);
                if (j == 5) q_s.push_back({8'(w), m});
                send(1'b1, 8'(8'h11 + 6 * w + j), 1'b0);
            end
        end
        dat_s = 8'h29;
        stb_s = 1'b1;
        @(negedge clk);
        check("small_we_last", 64'(we_s), 64'd1);
        check("small_done_early", 64'(done_s), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("small_done", 64'(done_s), 64'd1);
        check("small_hold", 64'(hold_s), 64'd0);
        check("small_25th_ack", 64'(ack_s), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("small_25th_ack_held", 64'(ack_s), 64'd0);
        check("small_we_count", 64'(we_cnt_s), 64'd4);
        check("small_word3", 64'(cap3s), 64'h282726252423);
        check("small_ack_protocol", 64'(ack_viol), 64'd0);
        check("small_sb_empty", 64'(q_s.size()), 64'd0);
        stb_s = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
